// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package bp_pkg;

    // 2-bit saturating counter encodings
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef logic [1:0] ctr2_t;

    // Move a counter one step toward the observed outcome, clamping at the ends
    function automatic ctr2_t sat_update(ctr2_t c, logic taken);
        ctr2_t r;
        if (taken) begin
            r = (c == ST) ? ST : ctr2_t'(c + 2'd1);
        end else begin
            r = (c == SNT) ? SNT : ctr2_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ghr_shift.sv
// Global history register with mispredict rollback.
// A restore reloads the history from the branch's snapshot plus its real
// outcome and takes priority over a speculative shift in the same cycle.
module ghr_shift #(
    parameter int HIST_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic              shift_bit_i,
    input  logic              restore_en_i,
    input  logic [HIST_W-1:0] restore_hist_i,
    input  logic              restore_bit_i,
    output logic [HIST_W-1:0] hist_o
);

    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_d;

    // Next history: recovery beats speculative shift, otherwise hold
    always_comb begin
        hist_d = hist_q;
        if (restore_en_i) begin
            hist_d = {restore_hist_i[HIST_W-2:0], restore_bit_i};
        end else if (shift_en_i) begin
            hist_d = {hist_q[HIST_W-2:0], shift_bit_i};
        end
    end

    // History register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign hist_o = hist_q;

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: PHT of 2-bit counters indexed by PC XOR global
// history. Prediction is a combinational read; training from execute writes
// one counter per cycle and a mispredict rolls the history back.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int HIST_W = 7,
    parameter int PC_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              predict_valid,
    input  logic [PC_W-1:0]   predict_pc,
    output logic              predict_taken,
    output logic [HIST_W-1:0] predict_history,
    input  logic              train_valid,
    input  logic              train_taken,
    input  logic              train_mispredicted,
    input  logic [HIST_W-1:0] train_history,
    input  logic [PC_W-1:0]   train_pc
);

    localparam int DEPTH = 1 << HIST_W;

    ctr2_t             pht_q [DEPTH];
    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] pidx;
    logic [HIST_W-1:0] tidx;
    logic              recover;

    // PC_W is required to equal HIST_W, so the XOR is a plain modulo-DEPTH index
    assign pidx    = HIST_W'(predict_pc) ^ hist;
    assign tidx    = HIST_W'(train_pc) ^ train_history;
    assign recover = train_valid & train_mispredicted;

    // Read port sees the counter before any same-cycle training (no bypass)
    assign predict_taken   = pht_q[pidx][1];
    assign predict_history = hist;

    ghr_shift #(
        .HIST_W(HIST_W)
    ) u_ghr (
        .clk           (clk),
        .reset         (reset),
        .shift_en_i    (predict_valid),
        .shift_bit_i   (predict_taken),
        .restore_en_i  (recover),
        .restore_hist_i(train_history),
        .restore_bit_i (train_taken),
        .hist_o        (hist)
    );

    // Pattern table: full re-init to weakly-not-taken on reset, else one trained entry per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= WNT;
            end
        end else if (train_valid) begin
            pht_q[tidx] <= sat_update(pht_q[tidx], train_taken);
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: directed scenarios plus a
// long randomized run against a behavioural model of counters and history.
module tb_gshare_branch_predictor;

    localparam int HW   = 7;
    localparam int N    = 1 << HW;
    localparam int MASK = N - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          predict_valid;
    logic [HW-1:0] predict_pc;
    logic          predict_taken;
    logic [HW-1:0] predict_history;
    logic          train_valid;
    logic          train_taken;
    logic          train_mispredicted;
    logic [HW-1:0] train_history;
    logic [HW-1:0] train_pc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counter values 0..3 and history as plain integers
    int m_pht [N];
    int m_hist;

    gshare_branch_predictor #(.HIST_W(HW), .PC_W(HW)) dut (
        .clk               (clk),
        .reset             (reset),
        .predict_valid     (predict_valid),
        .predict_pc        (predict_pc),
        .predict_taken     (predict_taken),
        .predict_history   (predict_history),
        .train_valid       (train_valid),
        .train_taken       (train_taken),
        .train_mispredicted(train_mispredicted),
        .train_history     (train_history),
        .train_pc          (train_pc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset              = 1'b0;
        predict_valid      = 1'b0;
        predict_pc         = '0;
        train_valid        = 1'b0;
        train_taken        = 1'b0;
        train_mispredicted = 1'b0;
        train_history      = '0;
        train_pc           = '0;
    endtask

    // Check combinational outputs against the model, clock once, advance the model
    task automatic tick();
        int pidx;
        int tidx;
        int pred;
        #1;
        pidx = (int'(predict_pc) ^ m_hist) & MASK;
        pred = (m_pht[pidx] >= 2) ? 1 : 0;
        check_val("model_taken", 32'(predict_taken), pred);
        check_val("model_hist", 32'(predict_history), m_hist);
        @(posedge clk);
        if (reset) begin
            m_hist = 0;
            for (int i = 0; i < N; i++) m_pht[i] = 1;
        end else begin
            if (train_valid && train_mispredicted)
                m_hist = ((int'(train_history) * 2) + int'(train_taken)) & MASK;
            else if (predict_valid)
                m_hist = ((m_hist * 2) + pred) & MASK;
            if (train_valid) begin
                tidx = (int'(train_pc) ^ int'(train_history)) & MASK;
                if (train_taken) m_pht[tidx] = (m_pht[tidx] == 3) ? 3 : m_pht[tidx] + 1;
                else             m_pht[tidx] = (m_pht[tidx] == 0) ? 0 : m_pht[tidx] - 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic train(input int pc, input int h, input logic tk, input logic misp);
        idle_inputs();
        train_valid        = 1'b1;
        train_pc           = HW'(pc);
        train_history      = HW'(h);
        train_taken        = tk;
        train_mispredicted = misp;
        tick();
        idle_inputs();
    endtask

    task automatic check_all_reset(input string tag);
        idle_inputs();
        for (int pc = 0; pc < N; pc++) begin
            predict_pc = HW'(pc);
            #1;
            check_val({tag, "_taken"}, 32'(predict_taken), 32'd0);
            check_val({tag, "_hist"}, 32'(predict_history), 32'd0);
        end
    endtask

    task automatic randomize_inputs(input bit allow_reset);
        reset              = allow_reset && ($urandom_range(0, 63) == 0);
        predict_valid      = 1'($urandom);
        predict_pc         = HW'($urandom);
        train_valid        = 1'($urandom);
        train_taken        = 1'($urandom);
        train_mispredicted = ($urandom_range(0, 3) == 0);
        train_history      = HW'($urandom);
        train_pc           = HW'($urandom);
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < N; i++) m_pht[i] = 1;
        m_hist = 0;
        @(posedge clk);
        #1;

        // 1: reset leaves every PC predicting not-taken with empty history
        do_reset();
        check_all_reset("reset");

        // 2: three predictions 1,0,1 shift into history as 0000101
        train(0, 0, 1'b1, 1'b0);
        train(2, 0, 1'b1, 1'b0);
        idle_inputs();
        predict_valid = 1'b1;
        predict_pc    = '0;
        #1 check_val("shift_p1", 32'(predict_taken), 32'd1);
        tick();
        #1 check_val("shift_p2", 32'(predict_taken), 32'd0);
        tick();
        #1 check_val("shift_p3", 32'(predict_taken), 32'd1);
        tick();
        idle_inputs();
        #1 check_val("shift_hist", 32'(predict_history), 32'h05);

        // 3: saturation up to ST and back down to SNT at pc=5, hist=0
        do_reset();
        for (int k = 0; k < 4; k++) train(5, 0, 1'b1, 1'b0);
        predict_pc = HW'(5);
        #1 check_val("sat_up", 32'(predict_taken), 32'd1);
        train(5, 0, 1'b0, 1'b0);
        predict_pc = HW'(5);
        #1 check_val("sat_dn1", 32'(predict_taken), 32'd1);
        train(5, 0, 1'b0, 1'b0);
        predict_pc = HW'(5);
        #1 check_val("sat_dn2", 32'(predict_taken), 32'd0);
        train(5, 0, 1'b0, 1'b0);
        train(5, 0, 1'b1, 1'b0);
        predict_pc = HW'(5);
        #1 check_val("sat_floor", 32'(predict_taken), 32'd0);

        // 4: recovery wins over a simultaneous prediction shift
        do_reset();
        train(0, 'h2A, 1'b1, 1'b1);
        #1 check_val("rec_setup", 32'(predict_history), 32'h55);
        idle_inputs();
        predict_valid      = 1'b1;
        predict_pc         = HW'(9);
        train_valid        = 1'b1;
        train_mispredicted = 1'b1;
        train_history      = HW'('h12);
        train_taken        = 1'b1;
        train_pc           = HW'(1);
        tick();
        idle_inputs();
        #1 check_val("rec_hist", 32'(predict_history), 32'h25);
        // mispredict flag without train_valid must not touch history
        train_mispredicted = 1'b1;
        train_history      = HW'('h7F);
        tick();
        idle_inputs();
        #1 check_val("misp_no_valid", 32'(predict_history), 32'h25);

        // 5: same-index predict and train: old value now, new value next cycle
        do_reset();
        predict_valid = 1'b1;
        predict_pc    = HW'(3);
        train_valid   = 1'b1;
        train_pc      = HW'(3);
        train_history = '0;
        train_taken   = 1'b1;
        #1 check_val("coll_same", 32'(predict_taken), 32'd0);
        tick();
        idle_inputs();
        predict_pc = HW'(3);
        #1 check_val("coll_next", 32'(predict_taken), 32'd1);

        // 6: random traffic, reset mid-operation, then a long checked random run
        for (int c = 0; c < 20; c++) begin
            randomize_inputs(1'b0);
            tick();
        end
        do_reset();
        check_all_reset("midop_reset");
        for (int c = 0; c < 2000; c++) begin
            randomize_inputs(1'b1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
